// File: rtl/tl_frag_pkg.sv
// Shared TileLink opcode constants, fragmenter FSM states and the fragment-count helper.
package tl_frag_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        D_ACK      = 3'd0,
        D_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } frag_state_e;

    // Number of beat-sized fragments needed to cover a 2^size byte transfer.
    function automatic int unsigned frag_count(input int unsigned size, input int unsigned lg_beat);
        return (size > lg_beat) ? (32'd1 << (size - lg_beat)) : 32'd1;
    endfunction

endpackage

// File: rtl/tl_frag_size_table.sv
// Per-source record of the original transfer size, restored onto the inbound D channel.
module tl_frag_size_table #(
    parameter int SRC_W  = 5,
    parameter int SIZE_W = 3
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [SRC_W-1:0]  wr_idx,
    input  logic [SIZE_W-1:0] wr_size,
    input  logic [SRC_W-1:0]  rd_idx,
    output logic [SIZE_W-1:0] rd_size
);

    logic [SIZE_W-1:0] mem [2**SRC_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_size;
        end
    end

    assign rd_size = mem[rd_idx];

endmodule

// File: rtl/tl_fragmenter_param.sv
// TL-UL fragmenter: splits transfers wider than one beat into beat-sized fragments and
// collapses the returning acknowledgements back into one response per original request.
module tl_fragmenter_param
    import tl_frag_pkg::*;
#(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = 6,
    parameter int SRC_W    = 5,
    parameter int SIZE_W   = 3,
    localparam int LG_BEAT = $clog2(DATA_W / 8),
    localparam int FRAG_W  = ((MAX_SIZE - LG_BEAT) > 1) ? (MAX_SIZE - LG_BEAT) : 1,
    localparam int OSIZE_W = ($clog2(LG_BEAT + 1) > 1) ? $clog2(LG_BEAT + 1) : 1,
    localparam int MASK_W  = DATA_W / 8,
    localparam int OSRC_W  = SRC_W + FRAG_W
) (
    input  logic               clock,
    input  logic               reset,

    output logic               in_a_ready,
    input  logic               in_a_valid,
    input  logic [2:0]         in_a_bits_opcode,
    input  logic [2:0]         in_a_bits_param,
    input  logic [SIZE_W-1:0]  in_a_bits_size,
    input  logic [SRC_W-1:0]   in_a_bits_source,
    input  logic [ADDR_W-1:0]  in_a_bits_address,
    input  logic [MASK_W-1:0]  in_a_bits_mask,
    input  logic [DATA_W-1:0]  in_a_bits_data,
    input  logic               in_a_bits_corrupt,

    input  logic               in_d_ready,
    output logic               in_d_valid,
    output logic [2:0]         in_d_bits_opcode,
    output logic [SIZE_W-1:0]  in_d_bits_size,
    output logic [SRC_W-1:0]   in_d_bits_source,
    output logic [DATA_W-1:0]  in_d_bits_data,

    input  logic               out_a_ready,
    output logic               out_a_valid,
    output logic [2:0]         out_a_bits_opcode,
    output logic [2:0]         out_a_bits_param,
    output logic [OSIZE_W-1:0] out_a_bits_size,
    output logic [OSRC_W-1:0]  out_a_bits_source,
    output logic [ADDR_W-1:0]  out_a_bits_address,
    output logic [MASK_W-1:0]  out_a_bits_mask,
    output logic [DATA_W-1:0]  out_a_bits_data,
    output logic               out_a_bits_corrupt,

    output logic               out_d_ready,
    input  logic               out_d_valid,
    input  logic [2:0]         out_d_bits_opcode,
    input  logic [OSIZE_W-1:0] out_d_bits_size,
    input  logic [OSRC_W-1:0]  out_d_bits_source,
    input  logic [DATA_W-1:0]  out_d_bits_data
);

    frag_state_e       state, state_n;
    logic [FRAG_W-1:0] rem_cnt, rem_cnt_n;
    logic [FRAG_W-1:0] frag_last;
    logic [FRAG_W-1:0] rem;
    logic [FRAG_W-1:0] frag_idx;
    logic              is_get;
    logic              wide;
    logic              a_fire;
    logic              first_frag;

    assign is_get    = (in_a_bits_opcode == A_GET);
    assign wide      = (in_a_bits_size >= SIZE_W'(LG_BEAT));
    assign frag_last = FRAG_W'(frag_count(32'(in_a_bits_size), LG_BEAT) - 32'd1);

    // While idle the first fragment is derived straight from the request so no cycle is lost.
    assign rem      = (state == ST_BURST) ? rem_cnt : frag_last;
    assign frag_idx = frag_last - rem;

    assign out_a_valid = in_a_valid & ~reset;
    assign in_a_ready  = out_a_ready & ~reset & (~is_get | (rem == '0));
    assign a_fire      = out_a_valid & out_a_ready;
    assign first_frag  = a_fire & (state == ST_IDLE);

    assign out_a_bits_opcode  = in_a_bits_opcode;
    assign out_a_bits_param   = in_a_bits_param;
    assign out_a_bits_size    = (in_a_bits_size > SIZE_W'(LG_BEAT)) ? OSIZE_W'(LG_BEAT)
                                                                    : OSIZE_W'(in_a_bits_size);
    assign out_a_bits_source  = {in_a_bits_source, rem};
    assign out_a_bits_address = in_a_bits_address | (ADDR_W'(frag_idx) << LG_BEAT);
    assign out_a_bits_mask    = (is_get && wide) ? {MASK_W{1'b1}} : in_a_bits_mask;
    assign out_a_bits_data    = in_a_bits_data;
    assign out_a_bits_corrupt = in_a_bits_corrupt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rem_cnt <= '0;
        end else begin
            state   <= state_n;
            rem_cnt <= rem_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        rem_cnt_n = rem_cnt;
        if (a_fire) begin
            if (state == ST_IDLE) begin
                if (frag_last != '0) begin
                    state_n   = ST_BURST;
                    rem_cnt_n = frag_last - 1'b1;
                end
            end else if (rem_cnt == '0) begin
                state_n = ST_IDLE;
            end else begin
                rem_cnt_n = rem_cnt - 1'b1;
            end
        end
    end

    logic [SRC_W-1:0]  d_src;
    logic [FRAG_W-1:0] d_rem;
    logic [SIZE_W-1:0] d_size;
    logic              d_drop;
    logic              unused_d_size;

    tl_frag_size_table #(
        .SRC_W  (SRC_W),
        .SIZE_W (SIZE_W)
    ) u_size_table (
        .clock   (clock),
        .wr_en   (first_frag),
        .wr_idx  (in_a_bits_source),
        .wr_size (in_a_bits_size),
        .rd_idx  (d_src),
        .rd_size (d_size)
    );

    assign d_src  = out_d_bits_source[OSRC_W-1:FRAG_W];
    assign d_rem  = out_d_bits_source[FRAG_W-1:0];
    // Write acks for all but the last fragment are swallowed; the last one stands for the whole put.
    assign d_drop = (out_d_bits_opcode == D_ACK) && (d_rem != '0);

    assign out_d_ready      = d_drop | in_d_ready;
    assign in_d_valid       = out_d_valid & ~d_drop & ~reset;
    assign in_d_bits_opcode = out_d_bits_opcode;
    assign in_d_bits_size   = d_size;
    assign in_d_bits_source = d_src;
    assign in_d_bits_data   = out_d_bits_data;

    assign unused_d_size = ^out_d_bits_size;

endmodule

// File: tb/tb_tl_fragmenter_param.sv
// Scoreboard bench for tl_fragmenter_param with directed TL-UL traffic on both channels.
module tb_tl_fragmenter_param;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = 5;
    localparam int SIZE_W  = 3;
    localparam int OSIZE_W = 2;
    localparam int OSRC_W  = 9;
    localparam int MASK_W  = 4;

    typedef struct packed {
        logic [2:0]         opcode;
        logic [2:0]         param;
        logic [OSIZE_W-1:0] size;
        logic [OSRC_W-1:0]  source;
        logic [ADDR_W-1:0]  address;
        logic [MASK_W-1:0]  mask;
        logic [DATA_W-1:0]  data;
        logic               corrupt;
    } a_bits_t;

    typedef struct packed {
        a_bits_t bits;
        logic    in_rdy;
    } a_exp_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic [DATA_W-1:0] data;
    } d_bits_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic               in_a_ready, in_a_valid;
    logic [2:0]         in_a_bits_opcode, in_a_bits_param;
    logic [SIZE_W-1:0]  in_a_bits_size;
    logic [SRC_W-1:0]   in_a_bits_source;
    logic [ADDR_W-1:0]  in_a_bits_address;
    logic [MASK_W-1:0]  in_a_bits_mask;
    logic [DATA_W-1:0]  in_a_bits_data;
    logic               in_a_bits_corrupt;
    logic               in_d_ready, in_d_valid;
    logic [2:0]         in_d_bits_opcode;
    logic [SIZE_W-1:0]  in_d_bits_size;
    logic [SRC_W-1:0]   in_d_bits_source;
    logic [DATA_W-1:0]  in_d_bits_data;
    logic               out_a_ready, out_a_valid;
    logic [2:0]         out_a_bits_opcode, out_a_bits_param;
    logic [OSIZE_W-1:0] out_a_bits_size;
    logic [OSRC_W-1:0]  out_a_bits_source;
    logic [ADDR_W-1:0]  out_a_bits_address;
    logic [MASK_W-1:0]  out_a_bits_mask;
    logic [DATA_W-1:0]  out_a_bits_data;
    logic               out_a_bits_corrupt;
    logic               out_d_ready, out_d_valid;
    logic [2:0]         out_d_bits_opcode;
    logic [OSIZE_W-1:0] out_d_bits_size;
    logic [OSRC_W-1:0]  out_d_bits_source;
    logic [DATA_W-1:0]  out_d_bits_data;

    logic rdy_force, toggle_en;
    logic tog = 1'b0;
    always @(posedge clock) tog <= ~tog;
    assign out_a_ready = toggle_en ? tog : rdy_force;

    tl_fragmenter_param dut (
        .clock              (clock),
        .reset              (reset),
        .in_a_ready         (in_a_ready),
        .in_a_valid         (in_a_valid),
        .in_a_bits_opcode   (in_a_bits_opcode),
        .in_a_bits_param    (in_a_bits_param),
        .in_a_bits_size     (in_a_bits_size),
        .in_a_bits_source   (in_a_bits_source),
        .in_a_bits_address  (in_a_bits_address),
        .in_a_bits_mask     (in_a_bits_mask),
        .in_a_bits_data     (in_a_bits_data),
        .in_a_bits_corrupt  (in_a_bits_corrupt),
        .in_d_ready         (in_d_ready),
        .in_d_valid         (in_d_valid),
        .in_d_bits_opcode   (in_d_bits_opcode),
        .in_d_bits_size     (in_d_bits_size),
        .in_d_bits_source   (in_d_bits_source),
        .in_d_bits_data     (in_d_bits_data),
        .out_a_ready        (out_a_ready),
        .out_a_valid        (out_a_valid),
        .out_a_bits_opcode  (out_a_bits_opcode),
        .out_a_bits_param   (out_a_bits_param),
        .out_a_bits_size    (out_a_bits_size),
        .out_a_bits_source  (out_a_bits_source),
        .out_a_bits_address (out_a_bits_address),
        .out_a_bits_mask    (out_a_bits_mask),
        .out_a_bits_data    (out_a_bits_data),
        .out_a_bits_corrupt (out_a_bits_corrupt),
        .out_d_ready        (out_d_ready),
        .out_d_valid        (out_d_valid),
        .out_d_bits_opcode  (out_d_bits_opcode),
        .out_d_bits_size    (out_d_bits_size),
        .out_d_bits_source  (out_d_bits_source),
        .out_d_bits_data    (out_d_bits_data)
    );

    int checks = 0;
    int errors = 0;
    a_exp_t  exp_a[$];
    d_bits_t exp_d[$];

    a_bits_t cur_a, held_a;
    d_bits_t cur_d;
    logic    stalled = 1'b0;

    assign cur_a = '{opcode: out_a_bits_opcode, param: out_a_bits_param, size: out_a_bits_size,
                     source: out_a_bits_source, address: out_a_bits_address, mask: out_a_bits_mask,
                     data: out_a_bits_data, corrupt: out_a_bits_corrupt};
    assign cur_d = '{opcode: in_d_bits_opcode, size: in_d_bits_size,
                     source: in_d_bits_source, data: in_d_bits_data};

    // Monitor: compares every handshake on out_a and in_d against the scoreboard queues.
    always @(negedge clock) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (in_a_valid && !(in_a_bits_opcode inside {3'd0, 3'd1, 3'd4}))
                assert (in_a_bits_size <= 3'd2) else $error("illegal wide opcode %0d", in_a_bits_opcode);
            if (stalled && out_a_valid) begin
                checks++;
                if (cur_a !== held_a) begin
                    errors++;
                    $display("FAIL out_a_stall_hold: got %h required %h", cur_a, held_a);
                end
            end
            stalled = out_a_valid && !out_a_ready;
            held_a  = cur_a;
            if (out_a_valid && out_a_ready) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL out_a_unexpected: got %h with nothing expected", cur_a);
                end else begin
                    a_exp_t e;
                    e = exp_a.pop_front();
                    if (cur_a !== e.bits || in_a_ready !== e.in_rdy) begin
                        errors++;
                        $display("FAIL out_a_frag: got %h in_a_ready=%b required %h in_a_ready=%b",
                                 cur_a, in_a_ready, e.bits, e.in_rdy);
                    end
                end
            end
            if (in_d_valid && in_d_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL in_d_unexpected: got %h with nothing expected", cur_d);
                end else begin
                    d_bits_t e;
                    e = exp_d.pop_front();
                    if (cur_d !== e) begin
                        errors++;
                        $display("FAIL in_d_resp: got %h required %h", cur_d, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic ea(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                      input logic [8:0] src, input logic [27:0] addr, input logic [3:0] msk,
                      input logic [31:0] dat, input logic cor, input logic rdy);
        a_exp_t e;
        e.bits = '{opcode: op, param: prm, size: sz, source: src, address: addr,
                   mask: msk, data: dat, corrupt: cor};
        e.in_rdy = rdy;
        exp_a.push_back(e);
    endtask

    task automatic ed(input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src,
                      input logic [31:0] dat);
        exp_d.push_back('{opcode: op, size: sz, source: src, data: dat});
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                          input logic [4:0] src, input logic [27:0] addr, input logic [3:0] msk,
                          input logic [31:0] dat);
        int t;
        in_a_bits_opcode  = op;
        in_a_bits_param   = prm;
        in_a_bits_size    = sz;
        in_a_bits_source  = src;
        in_a_bits_address = addr;
        in_a_bits_mask    = msk;
        in_a_bits_data    = dat;
        in_a_valid        = 1'b1;
        t = 0;
        @(negedge clock);
        while (!in_a_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!in_a_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: got no in_a_ready required acceptance of src %0d", src);
        end
        @(posedge clock);
        #1;
        in_a_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [8:0] src, input logic [31:0] dat);
        int t;
        out_d_bits_opcode = op;
        out_d_bits_size   = 2'd2;
        out_d_bits_source = src;
        out_d_bits_data   = dat;
        out_d_valid       = 1'b1;
        t = 0;
        @(negedge clock);
        while (!out_d_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!out_d_ready) begin
            checks++;
            errors++;
            $display("FAIL d_accept_timeout: got no out_d_ready required acceptance of src %0h", src);
        end
        @(posedge clock);
        #1;
        out_d_valid = 1'b0;
    endtask

    initial begin
        in_a_valid = 1'b0; in_a_bits_opcode = '0; in_a_bits_param = '0; in_a_bits_size = '0;
        in_a_bits_source = '0; in_a_bits_address = '0; in_a_bits_mask = '0;
        in_a_bits_data = '0; in_a_bits_corrupt = 1'b0;
        in_d_ready = 1'b1; rdy_force = 1'b1; toggle_en = 1'b0;
        out_d_bits_opcode = 3'd1; out_d_bits_size = 2'd2; out_d_bits_source = 9'h030;
        out_d_bits_data = '0;
        out_d_valid = 1'b1;

        // Reset: a pending response must not leak to in_d, no fragment is offered.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_d_valid", 32'(in_d_valid), 32'd0);
        chk("rst_out_a_valid", 32'(out_a_valid), 32'd0);
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_rem_cnt", 32'(dut.rem_cnt), 32'd0);
        out_d_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Get size 4 at 0x100 -> four beat reads, in_a_ready only on the last.
        ea(3'd4, 3'd0, 2'd2, 9'h033, 28'h100, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h032, 28'h104, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h031, 28'h108, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h030, 28'h10C, 4'hF, 32'hA5A5_0001, 1'b0, 1'b1);
        a_beat(3'd4, 3'd0, 3'd4, 5'd3, 28'h100, 4'h0, 32'hA5A5_0001);
        ed(3'd1, 3'd4, 5'd3, 32'h1111_0003); d_beat(3'd1, 9'h033, 32'h1111_0003);
        ed(3'd1, 3'd4, 5'd3, 32'h1111_0002); d_beat(3'd1, 9'h032, 32'h1111_0002);
        ed(3'd1, 3'd4, 5'd3, 32'h1111_0001); d_beat(3'd1, 9'h031, 32'h1111_0001);
        ed(3'd1, 3'd4, 5'd3, 32'h1111_0000); d_beat(3'd1, 9'h030, 32'h1111_0000);

        // PutFull size 3, two beats; only the final ack reaches in_d.
        ea(3'd0, 3'd0, 2'd2, 9'h071, 28'h200, 4'hF, 32'hDEAD_0001, 1'b0, 1'b1);
        ea(3'd0, 3'd0, 2'd2, 9'h070, 28'h204, 4'hF, 32'hDEAD_0002, 1'b0, 1'b1);
        a_beat(3'd0, 3'd0, 3'd3, 5'd7, 28'h200, 4'hF, 32'hDEAD_0001);
        a_beat(3'd0, 3'd0, 3'd3, 5'd7, 28'h200, 4'hF, 32'hDEAD_0002);
        d_beat(3'd0, 9'h071, 32'h0000_BAD0);
        ed(3'd0, 3'd3, 5'd7, 32'h0000_600D); d_beat(3'd0, 9'h070, 32'h0000_600D);

        // Single-beat Get passes through; narrow Get keeps its mask and corrupt bit.
        ea(3'd4, 3'd1, 2'd2, 9'h090, 28'h040, 4'hF, 32'h0000_0000, 1'b0, 1'b1);
        a_beat(3'd4, 3'd1, 3'd2, 5'd9, 28'h040, 4'h0, 32'h0000_0000);
        ed(3'd1, 3'd2, 5'd9, 32'hCAFE_0040); d_beat(3'd1, 9'h090, 32'hCAFE_0040);
        in_a_bits_corrupt = 1'b1;
        ea(3'd4, 3'd0, 2'd1, 9'h0A0, 28'h042, 4'h3, 32'h0000_0000, 1'b1, 1'b1);
        a_beat(3'd4, 3'd0, 3'd1, 5'd10, 28'h042, 4'h3, 32'h0000_0000);
        in_a_bits_corrupt = 1'b0;
        ed(3'd1, 3'd1, 5'd10, 32'hCAFE_0042); d_beat(3'd1, 9'h0A0, 32'hCAFE_0042);

        // out_a_ready toggling during a 4-fragment Get.
        toggle_en = 1'b1;
        ea(3'd4, 3'd0, 2'd2, 9'h023, 28'h300, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h022, 28'h304, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h021, 28'h308, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h020, 28'h30C, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
        a_beat(3'd4, 3'd0, 3'd4, 5'd2, 28'h300, 4'h0, 32'h1234_5678);
        toggle_en = 1'b0;

        // PutPartial size 4 with in_d_ready low: early acks drain, final ack waits.
        in_d_ready = 1'b0;
        ea(3'd1, 3'd0, 2'd2, 9'h043, 28'h400, 4'h5, 32'h0000_0A00, 1'b0, 1'b1);
        ea(3'd1, 3'd0, 2'd2, 9'h042, 28'h404, 4'h5, 32'h0000_0A01, 1'b0, 1'b1);
        ea(3'd1, 3'd0, 2'd2, 9'h041, 28'h408, 4'h5, 32'h0000_0A02, 1'b0, 1'b1);
        ea(3'd1, 3'd0, 2'd2, 9'h040, 28'h40C, 4'h5, 32'h0000_0A03, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            a_beat(3'd1, 3'd0, 3'd4, 5'd4, 28'h400, 4'h5, 32'h0000_0A00 + 32'(i));
        d_beat(3'd0, 9'h043, 32'h0000_0003);
        d_beat(3'd0, 9'h042, 32'h0000_0002);
        d_beat(3'd0, 9'h041, 32'h0000_0001);
        out_d_bits_opcode = 3'd0; out_d_bits_source = 9'h040; out_d_bits_data = 32'h0000_7777;
        out_d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("final_ack_in_d_valid", 32'(in_d_valid), 32'd1);
            chk("final_ack_held", 32'(out_d_ready), 32'd0);
        end
        ed(3'd0, 3'd4, 5'd4, 32'h0000_7777);
        @(posedge clock);
        #1 in_d_ready = 1'b1;
        @(negedge clock);
        chk("final_ack_released", 32'(out_d_ready), 32'd1);
        @(posedge clock);
        #1 out_d_valid = 1'b0;

        // Reset after fragment 2 of 4, then the same Get must restart from remaining 3.
        ea(3'd4, 3'd0, 2'd2, 9'h063, 28'h500, 4'hF, 32'h5555_0000, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h062, 28'h504, 4'hF, 32'h5555_0000, 1'b0, 1'b0);
        in_a_bits_opcode = 3'd4; in_a_bits_param = 3'd0; in_a_bits_size = 3'd4;
        in_a_bits_source = 5'd6; in_a_bits_address = 28'h500; in_a_bits_mask = 4'h0;
        in_a_bits_data = 32'h5555_0000;
        in_a_valid = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_a_valid = 1'b0;
        @(negedge clock);
        chk("mid_burst_rst_state", 32'(dut.state), 32'd0);
        chk("mid_burst_rst_rem_cnt", 32'(dut.rem_cnt), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        ea(3'd4, 3'd0, 2'd2, 9'h063, 28'h500, 4'hF, 32'h5555_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h062, 28'h504, 4'hF, 32'h5555_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h061, 28'h508, 4'hF, 32'h5555_0001, 1'b0, 1'b0);
        ea(3'd4, 3'd0, 2'd2, 9'h060, 28'h50C, 4'hF, 32'h5555_0001, 1'b0, 1'b1);
        a_beat(3'd4, 3'd0, 3'd4, 5'd6, 28'h500, 4'h0, 32'h5555_0001);

        for (int t = 0; t < 50 && (exp_a.size() != 0 || exp_d.size() != 0); t++)
            @(negedge clock);
        chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
        chk("exp_d_drained", 32'(exp_d.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
